// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types and constants for the data/instruction SRAM-style bridges:
// FSM encoding, transfer size codes and the fixed kseg0/kseg1 mapping constants.
package dmem_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // kseg0 (0x8000_0000) and kseg1 (0xA000_0000) share the top two bits 10;
  // both map onto the low 512 MB by clearing the top three bits.
  localparam logic [1:0] KSEG01_TAG    = 2'b10;
  localparam logic [2:0] KSEG_PHYS_TOP = 3'b000;

  function automatic logic [1:0] size_of(input logic [3:0] mask);
    logic [1:0] sz;
    sz = SZ_WORD;
    case (mask)
      4'b0011, 4'b1100:                   sz = SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = SZ_BYTE;
      default:                            sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_sram_bridge_mmu.sv
// Fixed virtual-to-physical translation, purely combinational, shared with the
// instruction-side bridge. MAP_EN=0 turns it into a wire.
module mmu_fixed
  import dmem_sram_bridge_pkg::*;
#(
  parameter int MAP_EN = 1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (MAP_EN != 0 && vaddr[31:30] == KSEG01_TAG) begin
      paddr[31:29] = KSEG_PHYS_TOP;
    end
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// M-stage load/store to SRAM-like bus bridge; min 2 cycles from mem_enM to data.
// d_stall holds the pipeline until data returns; DONE parks results while stalled.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_MAP_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic [3:0]  sig_write,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        longest_stall,
  output logic [31:0] readdataM,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  state_t      state;
  logic [31:0] paddr;

  mmu_fixed #(
    .MAP_EN(ADDR_MAP_EN)
  ) u_mmu (
    .vaddr(aluoutM),
    .paddr(paddr)
  );

  // DONE releases the stall so the pipeline can advance past this access.
  assign d_stall = mem_enM & (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
      readdataM  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_enM) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= |sig_write;
            data_size  <= size_of(sig_write);
            data_addr  <= paddr;
            data_wdata <= writedataM;
          end
        end
        REQ: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              state <= DONE;
              if (!data_wr) readdataM <= data_rdata;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            state <= DONE;
            if (!data_wr) readdataM <= data_rdata;
          end
        end
        DONE: begin
          if (!longest_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Scoreboard bench: expected bus requests and load data are queued as each
// access is driven, then compared when the bridge issues or completes it.
module tb_dmem_sram_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_exp_t;

  logic        clk;
  logic        rst;
  logic        mem_enM;
  logic [3:0]  sig_write;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic        longest_stall;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] readdataM,  pt_readdataM;
  logic        d_stall,    pt_d_stall;
  logic        data_req,   pt_data_req;
  logic        data_wr,    pt_data_wr;
  logic [1:0]  data_size,  pt_data_size;
  logic [31:0] data_addr,  pt_data_addr;
  logic [31:0] data_wdata, pt_data_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cycles = 0;
  int req_rises  = 0;
  logic req_prev = 1'b0;
  logic [31:0] last_rd = 32'h0;

  req_exp_t    req_q[$];
  logic [31:0] pt_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] st_va[6];
  logic [3:0]  st_sw[6];
  logic [31:0] st_pa[6];
  logic [1:0]  st_sz[6];

  dmem_sram_bridge #(.ADDR_MAP_EN(1)) dut (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .sig_write(sig_write),
    .aluoutM(aluoutM), .writedataM(writedataM), .longest_stall(longest_stall),
    .readdataM(readdataM), .d_stall(d_stall), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  dmem_sram_bridge #(.ADDR_MAP_EN(0)) u_pt (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .sig_write(sig_write),
    .aluoutM(aluoutM), .writedataM(writedataM), .longest_stall(longest_stall),
    .readdataM(pt_readdataM), .d_stall(pt_d_stall), .data_req(pt_data_req),
    .data_wr(pt_data_wr), .data_size(pt_data_size), .data_addr(pt_data_addr),
    .data_wdata(pt_data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request monitor: each accepted request must match the oldest queued one.
  always @(negedge clk) begin
    if (rst) begin
      if (data_req) req_cycles++;
      if (data_req && !req_prev) req_rises++;
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'(data_req), 32'd0);
        end else begin
          req_exp_t e;
          e = req_q.pop_front();
          chk("req_addr",  data_addr,  e.addr);
          chk("req_wr",    32'(data_wr),   32'(e.wr));
          chk("req_size",  32'(data_size), 32'(e.size));
          chk("req_wdata", data_wdata, e.wdata);
        end
      end
      if (pt_data_req && data_addr_ok) begin
        if (pt_q.size() == 0) chk("pt_unexpected", 32'(pt_data_req), 32'd0);
        else chk("pt_addr", pt_data_addr, pt_q.pop_front());
      end
    end
    req_prev = data_req;
  end

  task automatic do_txn(input logic [31:0] va, input logic [3:0] sw, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [31:0] exp_addr,
                        input logic [1:0] exp_size, input int a_dly, input int d_dly,
                        input int hold);
    logic [31:0] exp_rd;
    exp_rd  = (sw == 4'b0000) ? rd : last_rd;
    last_rd = exp_rd;
    req_q.push_back('{addr: exp_addr, wr: (sw != 4'b0000), size: exp_size, wdata: wd});
    pt_q.push_back(va);
    rd_q.push_back(exp_rd);

    mem_enM = 1'b1; sig_write = sw; aluoutM = va; writedataM = wd;
    longest_stall = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = 32'hBAD0_0000;
    #1;
    chk("stall_c0", 32'(d_stall), 32'd1);
    chk("req_c0", 32'(data_req), 32'd0);
    step();
    for (int i = 0; i < a_dly; i++) begin
      chk("req_hold", 32'(data_req), 32'd1);
      chk("stall_req", 32'(d_stall), 32'd1);
      step();
    end
    chk("req_ack", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1; data_data_ok = (d_dly == 0); data_rdata = rd;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hBAD0_0001;
    if (d_dly > 0) begin
      for (int j = 1; j < d_dly; j++) begin
        chk("wait_noreq", 32'(data_req), 32'd0);
        chk("wait_stall", 32'(d_stall), 32'd1);
        step();
      end
      data_data_ok = 1'b1; data_rdata = rd;
      step();
      data_data_ok = 1'b0; data_rdata = 32'hBAD0_0002;
    end
    exp_rd = rd_q.pop_front();
    for (int k = 0; k <= hold; k++) begin
      longest_stall = (k < hold);
      if (k < hold) begin
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = ~rd;
      end
      #1;
      chk("done_stall", 32'(d_stall), 32'd0);
      chk("done_noreq", 32'(data_req), 32'd0);
      chk("done_rdata", readdataM, exp_rd);
      chk("done_state", 32'(dut.state), 32'd3);
      step();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
    end
    mem_enM = 1'b0; sig_write = 4'b0000; longest_stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_noreq", 32'(data_req), 32'd0);
      step();
    end
  endtask

  initial begin
    int r0, c0;
    st_va = '{32'h0000_1000, 32'hA000_0102, 32'hC000_0000, 32'h4000_0004, 32'h8000_0001, 32'h1FC0_0003};
    st_sw = '{4'b0011, 4'b1100, 4'b1111, 4'b0110, 4'b0010, 4'b1000};
    st_pa = '{32'h0000_1000, 32'h0000_0102, 32'hC000_0000, 32'h4000_0004, 32'h0000_0001, 32'h1FC0_0003};
    st_sz = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};

    rst = 1'b0; mem_enM = 1'b0; sig_write = 4'b0; aluoutM = 32'h0; writedataM = 32'h0;
    longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #2;
    chk("rst_req",   32'(data_req),  32'd0);
    chk("rst_wr",    32'(data_wr),   32'd0);
    chk("rst_size",  32'(data_size), 32'd0);
    chk("rst_addr",  data_addr,  32'h0);
    chk("rst_wdata", data_wdata, 32'h0);
    chk("rst_rdata", readdataM,  32'h0);
    chk("rst_stall0", 32'(d_stall), 32'd0);
    mem_enM = 1'b1;
    #1;
    chk("rst_stall1", 32'(d_stall), 32'd1);
    mem_enM = 1'b0;
    step();
    rst = 1'b1;
    idle(2);

    // Load word through kseg1, minimum latency
    do_txn(32'hBFC0_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 32'h1FC0_0010, 2'd2, 0, 0, 0);
    idle(2);

    // Byte store, slow address and data handshakes
    c0 = req_cycles;
    do_txn(32'h8000_0002, 4'b0100, 32'h00AB_0000, 32'h0, 32'h0000_0002, 2'd0, 3, 2, 0);
    chk("store_req_cycles", 32'(req_cycles - c0), 32'd4);
    idle(1);

    // Data returns while the pipeline stays stalled for 5 more cycles
    r0 = req_rises;
    do_txn(32'h0000_0200, 4'b0000, 32'h0, 32'h1234_5678, 32'h0000_0200, 2'd2, 1, 1, 5);
    chk("held_one_req", 32'(req_rises - r0), 32'd1);
    idle(1);

    // Back-to-back loads with mem_enM held across the boundary
    r0 = req_rises;
    do_txn(32'h8000_0100, 4'b0000, 32'h0, 32'h1111_0001, 32'h0000_0100, 2'd2, 0, 0, 0);
    do_txn(32'h8000_0104, 4'b0000, 32'h0, 32'h2222_0002, 32'h0000_0104, 2'd2, 0, 1, 0);
    chk("b2b_two_reqs", 32'(req_rises - r0), 32'd2);
    idle(1);

    // Store masks and address regions; stores leave readdataM alone
    for (int i = 0; i < 6; i++) begin
      do_txn(st_va[i], st_sw[i], $urandom, 32'hFFFF_FFFF, st_pa[i], st_sz[i], i % 3, (i + 1) % 2, 0);
      idle(1);
    end

    // Pass-through instance sees the raw kseg0 address
    do_txn(32'h9000_0000, 4'b0000, 32'h0, 32'h5A5A_5A5A, 32'h1000_0000, 2'd2, 0, 0, 0);
    idle(1);

    // Reset during WAIT, then a late data_ok after release
    req_q.push_back('{addr: 32'h0000_0040, wr: 1'b0, size: 2'd2, wdata: 32'h0});
    pt_q.push_back(32'h8000_0040);
    mem_enM = 1'b1; aluoutM = 32'h8000_0040; sig_write = 4'b0000; writedataM = 32'h0;
    longest_stall = 1'b1;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b0;
    step();
    data_addr_ok = 1'b0;
    chk("pre_rst_wait", 32'(dut.state), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdata", readdataM, 32'h0);
    chk("mid_rst_req",   32'(data_req), 32'd0);
    chk("mid_rst_addr",  data_addr, 32'h0);
    chk("mid_rst_state", 32'(dut.state), 32'd0);
    chk("mid_rst_stall", 32'(d_stall), 32'd1);
    mem_enM = 1'b0; longest_stall = 1'b0;
    step();
    step();
    rst = 1'b1;
    r0 = req_rises;
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    step();
    data_data_ok = 1'b0;
    step();
    step();
    chk("late_ok_rdata", readdataM, 32'h0);
    chk("late_ok_state", 32'(dut.state), 32'd0);
    chk("late_ok_noreq", 32'(req_rises - r0), 32'd0);
    chk("late_ok_req",   32'(data_req), 32'd0);

    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("pt_q_empty",  32'(pt_q.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
